// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8-bit UART transmitter, 8N1 framing (8E1 with UART_TX_PARITY_EN)
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   transmit  request level; a low-to-high transition asks for one frame
//   tx_data   byte to send, sampled when a request is accepted
//   txd       registered serial line, idle high
//   tx_done   registered, high when idle/ready, low while a frame is in flight
//
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit after
// the data bits. With it undefined the parity state and its logic are absent.

module uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       transmit,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tx_done
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        PARITY = 3'd4
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_d;
    logic        done_d;
    logic        transmit_q;
    logic        request;
    logic        bit_end;

    // transmit_q resets high so a request held through reset is not seen
    // as a fresh edge once reset releases.
    assign request = transmit & ~transmit_q;
    assign bit_end = (cnt_q == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            idx_q      <= 3'd0;
            shift_q    <= 8'd0;
            txd        <= 1'b1;
            tx_done    <= 1'b1;
            transmit_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            txd        <= txd_d;
            tx_done    <= done_d;
            transmit_q <= transmit;
        end
    end

    // Outputs are computed one step ahead so that txd/tx_done change on the
    // same edge as the state they belong to.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        txd_d   = txd;
        done_d  = tx_done;

        case (state_q)
            IDLE: begin
                txd_d  = 1'b1;
                done_d = 1'b1;
                cnt_d  = 16'd0;
                idx_d  = 3'd0;
                if (request) begin
                    shift_d = tx_data;
                    txd_d   = 1'b0;
                    done_d  = 1'b0;
                    state_d = START;
                end
            end

            START: begin
                if (bit_end) begin
                    cnt_d   = 16'd0;
                    idx_d   = 3'd0;
                    txd_d   = shift_q[0];
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    cnt_d = 16'd0;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = ^shift_q;
                        state_d = PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        txd_d = shift_q[idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = 16'd0;
                    txd_d   = 1'b1;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif

            STOP: begin
                if (bit_end) begin
                    cnt_d   = 16'd0;
                    txd_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
                idx_d   = 3'd0;
                txd_d   = 1'b1;
                done_d  = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (434 = 50 MHz / 115200), legal range 2..65535.
REQ-002 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port transmit  input  1  level request from the IO register block; a low-to-high transition requests one frame.
REQ-005 The block SHALL have port tx_data  input  8  byte to send; sampled only when a request is accepted.
REQ-006 The block SHALL have port txd  output  1  serial line, idle high, registered.
REQ-007 The block SHALL have port tx_done  output  1  level, high when idle and ready, low while a frame is in progress; registered.

Function
REQ-008 The block SHALL hold a registered copy transmit_q of transmit; a request is a cycle where transmit=1 and transmit_q=0.
REQ-009 The block SHALL accept a request only in state IDLE; requests in any other state SHALL be discarded, not queued.
REQ-010 On acceptance at clock edge N the block SHALL latch tx_data into a shift register, clear tx_done and enter START; txd SHALL be 0 from edge N.
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY (present only per REQ-021) and STOP; it SHALL never hold an unlisted encoding.
REQ-012 Each of START, each DATA bit, PARITY and STOP SHALL drive txd for exactly CLKS_PER_BIT cycles, timed by a 16-bit counter that counts 0..CLKS_PER_BIT-1 and restarts at every bit boundary.
REQ-013 DATA SHALL send 8 bits LSB first, using a 3-bit index; after bit 7 the FSM SHALL go to PARITY if compiled in, else STOP.
REQ-014 STOP SHALL drive txd=1; at the end of the stop bit the FSM SHALL enter IDLE and set tx_done=1 on the same edge.
REQ-015 Frame length from acceptance edge to tx_done rising SHALL be 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
REQ-016 A request in the last cycle of STOP SHALL be discarded, since the FSM is not yet IDLE; the earliest accepted request is the cycle after tx_done rises.
REQ-017 Changes on tx_data during a frame SHALL not affect the frame in progress.
REQ-018 transmit held high across frames SHALL start no further frames; each frame needs a fresh low-to-high transition.

Reset
REQ-019 While rst=1 the block SHALL force txd=1, tx_done=1, state=IDLE, counter=0, bit index=0, shift register=0 and transmit_q=1, asynchronously.
REQ-020 Reset mid-frame SHALL abort the frame immediately; transmit_q=1 SHALL stop transmit held high through reset from starting a frame after reset release.

Configuration
REQ-021 With macro UART_TX_PARITY_EN defined, the block SHALL insert a PARITY state after DATA, driving even parity (XOR of the 8 latched data bits) for CLKS_PER_BIT cycles (8E1 framing); without it, PARITY and its logic SHALL be absent and the framing SHALL be 8N1.

Verification (CLKS_PER_BIT=4)
REQ-022 Reset: assert rst with transmit=1 -> txd=1 and tx_done=1 at once; after release with transmit still 1, no frame starts.
REQ-023 Send 0xA5: transmit 0->1 -> txd = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_done low for exactly 40 cycles (44 with parity, parity bit 0).
REQ-024 Retrigger: after REQ-023 frame keep transmit=1 for 100 cycles -> txd stays 1; then drive transmit 0 then 1 with tx_data=0x01 -> frame 0,1,0,0,0,0,0,0,0,1 (parity bit 1 when enabled).
REQ-025 Busy: at cycle 10 of a 0x3C frame toggle transmit 0->1 and change tx_data to 0xFF -> 0x3C completes unchanged and no second frame follows.
REQ-026 Abort: assert rst at cycle 17 of a frame -> txd=1 and tx_done=1 at once; after release, a new request for 0x55 sends a complete, correct frame.
